// File: rtl/decomp1_seq.sv
// Job sequencer for decompress1: streams 32 message bytes into the decompressor
// and drains its 128 coefficient pairs into the polynomial RAM.
module decomp1_seq #(
   parameter int MSG_BYTES = 32,
   parameter int PAIRS     = 128,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        set,
   input  logic        start,
   output logic        msg_rd,
   output logic [4:0]  msg_addr,
   input  logic [7:0]  msg_data,
   output logic        d_readin,
   input  logic        d_readin_ok,
   output logic [7:0]  d_din,
   output logic [7:0]  d_in_index,
   output logic        d_full_in,
   output logic        d_readout,
   input  logic        d_readout_ok,
   input  logic [15:0] d_dout_1,
   input  logic [15:0] d_dout_2,
   input  logic [7:0]  d_out_index,
   input  logic        d_done,
   input  logic        poly_ready,
   output logic        poly_we,
   output logic [6:0]  poly_addr,
   output logic [31:0] poly_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_DRAIN, S_FINISH} state_t;

   state_t      r_state, w_state_next;
   logic [7:0]  r_byte_cnt, r_pair_cnt, r_hold;
   logic [9:0]  r_stall, w_stall_inc;
   logic        r_fetch_wait, r_done_seen, r_err, r_we;
   logic [6:0]  r_addr;
   logic [31:0] r_wdata;
   logic        w_run, w_in_xfer, w_out_xfer, w_order_bad;
   logic        w_stall_cnt_en, w_timeout, w_last_byte, w_drained;

   assign w_run          = set && ((r_state == S_FETCH) || (r_state == S_PRESENT) || (r_state == S_DRAIN));
   assign w_in_xfer      = d_readin && d_readin_ok;
   assign w_out_xfer     = d_readout && d_readout_ok;
   assign w_order_bad    = w_out_xfer && (d_out_index != r_pair_cnt);
   assign w_stall_cnt_en = (r_state == S_PRESENT) || (r_state == S_DRAIN);
   assign w_stall_inc    = r_stall + 10'd1;
   // Fire one cycle early so the FINISH cycle is the TIMEOUT-th cycle after the last transfer
   assign w_timeout      = w_stall_cnt_en && !w_in_xfer && !w_out_xfer && (w_stall_inc == 10'(TIMEOUT - 1));
   assign w_last_byte    = (r_byte_cnt == 8'(MSG_BYTES - 1));
   assign w_drained      = (r_pair_cnt == 8'(PAIRS)) && (r_done_seen || d_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else if (set) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_state_next = S_FETCH;
         S_FETCH: begin
            if (w_order_bad)       w_state_next = S_FINISH;
            else if (r_fetch_wait) w_state_next = S_PRESENT;
         end
         S_PRESENT: begin
            if (w_order_bad || w_timeout) w_state_next = S_FINISH;
            else if (w_in_xfer)           w_state_next = w_last_byte ? S_DRAIN : S_FETCH;
         end
         S_DRAIN:   if (w_order_bad || w_timeout || w_drained) w_state_next = S_FINISH;
         S_FINISH:  w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // Strobes are qualified by set so a frozen job presents nothing to its peers
   always_comb begin
      msg_rd    = 1'b0;
      d_readin  = 1'b0;
      d_full_in = 1'b0;
      d_readout = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_FETCH: begin
            msg_rd    = set && !r_fetch_wait;
            d_readout = set && poly_ready;
            busy      = 1'b1;
         end
         S_PRESENT: begin
            d_readin  = set;
            d_full_in = set && w_last_byte;
            d_readout = set && poly_ready;
            busy      = 1'b1;
         end
         S_DRAIN: begin
            d_readout = set && poly_ready;
            busy      = 1'b1;
         end
         S_FINISH: done = set;
         default: ;
      endcase
   end

   assign msg_addr   = r_byte_cnt[4:0];
   assign d_din      = r_hold;
   assign d_in_index = r_byte_cnt;
   assign poly_we    = set && r_we;
   assign poly_addr  = r_addr;
   assign poly_wdata = r_wdata;
   assign err        = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_cnt   <= '0;
         r_pair_cnt   <= '0;
         r_hold       <= '0;
         r_stall      <= '0;
         r_fetch_wait <= 1'b0;
         r_done_seen  <= 1'b0;
         r_err        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else if (set) begin
         r_we <= 1'b0;
         if (r_state == S_IDLE && start) begin
            r_byte_cnt   <= '0;
            r_pair_cnt   <= '0;
            r_stall      <= '0;
            r_fetch_wait <= 1'b0;
            r_done_seen  <= 1'b0;
            r_err        <= 1'b0;
         end
         // Second FETCH cycle: the message RAM output is valid now
         if (r_state == S_FETCH) begin
            r_fetch_wait <= !r_fetch_wait;
            if (r_fetch_wait) r_hold <= msg_data;
         end
         if (w_in_xfer) r_byte_cnt <= r_byte_cnt + 8'd1;
         if (w_out_xfer && !w_order_bad) begin
            r_we       <= 1'b1;
            r_addr     <= r_pair_cnt[6:0];
            r_wdata    <= {d_dout_2, d_dout_1};
            r_pair_cnt <= r_pair_cnt + 8'd1;
         end
         if (w_in_xfer || w_out_xfer) r_stall <= '0;
         else if (w_stall_cnt_en)     r_stall <= w_stall_inc;
         if (w_run && d_done) r_done_seen <= 1'b1;
         if (w_order_bad || w_timeout) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_decomp1_seq.sv
// Scoreboard bench for decomp1_seq: a message RAM, a decompressor model and a
// polynomial RAM surround the sequencer; expected traffic is queued up front.
module tb_decomp1_seq;
   localparam int TIMEOUT = 1023;

   typedef struct { int addr; logic [31:0] data; } wr_t;
   typedef struct { logic [7:0] din; logic [7:0] idx; logic full; } in_t;

   logic        clk = 1'b0;
   logic        reset, set, start;
   logic        msg_rd;
   logic [4:0]  msg_addr;
   logic [7:0]  msg_data = 8'h00;
   logic        d_readin, d_readin_ok, d_full_in;
   logic [7:0]  d_din, d_in_index;
   logic        d_readout, d_readout_ok, d_done;
   logic [15:0] d_dout_1, d_dout_2;
   logic [7:0]  d_out_index;
   logic        poly_ready, poly_we;
   logic [6:0]  poly_addr;
   logic [31:0] poly_wdata;
   logic        busy, done, err;

   decomp1_seq #(.MSG_BYTES(32), .PAIRS(128), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .set(set), .start(start),
      .msg_rd(msg_rd), .msg_addr(msg_addr), .msg_data(msg_data),
      .d_readin(d_readin), .d_readin_ok(d_readin_ok), .d_din(d_din),
      .d_in_index(d_in_index), .d_full_in(d_full_in),
      .d_readout(d_readout), .d_readout_ok(d_readout_ok), .d_dout_1(d_dout_1),
      .d_dout_2(d_dout_2), .d_out_index(d_out_index), .d_done(d_done),
      .poly_ready(poly_ready), .poly_we(poly_we), .poly_addr(poly_addr),
      .poly_wdata(poly_wdata), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0, n_errors = 0;
   int          cyc = 0;
   int          done_cnt = 0, done_cyc = 0, bad_cyc = 0, last_xfer_cyc = 0;
   int          start_cyc = 0, nominal_lat = 0;
   int          mp = 0, rx_cnt = 0;
   int          fault_pair = -1, stop_at = -1;
   logic        bp_mode = 1'b0, model_clr = 1'b0, ram_clr = 1'b0;
   logic        in_ok_r = 1'b1, prdy_r = 1'b1;
   logic [7:0]  msg_mem [0:31];
   logic [31:0] poly_mem [0:127];
   logic [31:0] nom_mem [0:127];
   int          wcount [0:127];
   logic [7:0]  mb;
   int          sh;
   wr_t         wr_q [$];
   in_t         in_q [$];
   logic        done_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (msg_rd) msg_data <= msg_mem[msg_addr];

   always @(posedge clk) begin
      if (bp_mode) begin
         in_ok_r <= 1'($urandom_range(0, 1));
         prdy_r  <= 1'($urandom_range(0, 1));
      end else begin
         in_ok_r <= 1'b1;
         prdy_r  <= 1'b1;
      end
   end
   assign d_readin_ok = in_ok_r;
   assign poly_ready  = prdy_r;

   // Decompressor model: pair p needs byte p/4; bits 2k,2k+1 map to 0 or 1665
   always @(posedge clk) begin
      if (reset || model_clr) begin
         rx_cnt <= 0;
         mp     <= 0;
      end else begin
         if (d_readin && d_readin_ok)   rx_cnt <= rx_cnt + 1;
         if (d_readout && d_readout_ok) mp     <= mp + 1;
      end
   end

   always_comb begin
      mb = 8'h00;
      if (mp < 128) mb = msg_mem[mp / 4];
      sh = (mp % 4) * 2;
      d_dout_1     = mb[sh]     ? 16'd1665 : 16'd0;
      d_dout_2     = mb[sh + 1] ? 16'd1665 : 16'd0;
      d_out_index  = (mp == fault_pair) ? 8'(mp + 1) : 8'(mp);
      d_readout_ok = (mp < 4 * rx_cnt) && (mp < 128) && ((stop_at < 0) || (mp < stop_at));
      d_done       = (mp >= 128);
   end

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 128; i++) wcount[i] <= 0;
      end else if (poly_we) begin
         poly_mem[poly_addr] <= poly_wdata;
         wcount[poly_addr]   <= wcount[poly_addr] + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] exp_word(input int a);
      logic [7:0] b;
      int s;
      b = msg_mem[a / 4];
      s = (a % 4) * 2;
      return {b[s + 1] ? 16'd1665 : 16'd0, b[s] ? 16'd1665 : 16'd0};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a transaction
   initial begin
      wr_t e_wr;
      in_t e_in;
      logic e_err;
      forever begin
         @(negedge clk);
         if ((d_readin && d_readin_ok) || (d_readout && d_readout_ok)) last_xfer_cyc = cyc;
         if (d_readout && d_readout_ok && (mp == fault_pair)) bad_cyc = cyc;
         if (d_readin && d_readin_ok) begin
            $display("IN   cyc=%0d idx=%0d din=%02h full=%0b", cyc, d_in_index, d_din, d_full_in);
            chk("in_expected", 64'(in_q.size() != 0), 64'd1);
            if (in_q.size() != 0) begin
               e_in = in_q.pop_front();
               chk("in_din", 64'(d_din), 64'(e_in.din));
               chk("in_index", 64'(d_in_index), 64'(e_in.idx));
               chk("in_full", 64'(d_full_in), 64'(e_in.full));
            end
         end
         if (poly_we) begin
            $display("WR   cyc=%0d addr=%0d data=%08h", cyc, poly_addr, poly_wdata);
            chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
               e_wr = wr_q.pop_front();
               chk("wr_addr", 64'(poly_addr), 64'(e_wr.addr));
               chk("wr_data", 64'(poly_wdata), 64'(e_wr.data));
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            $display("DONE cyc=%0d err=%0b busy=%0b", cyc, err, busy);
            chk("done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0) begin
               e_err = done_q.pop_front();
               chk("done_err", 64'(err), 64'(e_err));
               chk("done_busy", 64'(busy), 64'd0);
            end
         end
      end
   end

   task automatic push_job(input int n_wr, input bit exp_done, input bit exp_err);
      for (int a = 0; a < n_wr; a++) wr_q.push_back('{addr: a, data: exp_word(a)});
      for (int i = 0; i < 32; i++) in_q.push_back('{din: msg_mem[i], idx: 8'(i), full: (i == 31)});
      if (exp_done) done_q.push_back(exp_err);
   endtask

   task automatic start_job();
      @(posedge clk); #1;
      start = 1'b1; model_clr = 1'b1; ram_clr = 1'b1; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0; model_clr = 1'b0; ram_clr = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      bit got;
      d0 = done_cnt;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      chk("done_within_budget", 64'(got), 64'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_queues(input string tag);
      chk({tag, "_writes_left"}, 64'(wr_q.size()), 64'd0);
      chk({tag, "_inputs_left"}, 64'(in_q.size()), 64'd0);
      chk({tag, "_dones_left"}, 64'(done_q.size()), 64'd0);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_strobes"}, 64'({msg_rd, d_readin, d_full_in, d_readout, poly_we, busy, done, err}), 64'd0);
      chk({tag, "_data"}, 64'({poly_wdata, d_din, d_in_index, poly_addr, msg_addr}), 64'd0);
   endtask

   task automatic check_ram(input string tag);
      int diffs;
      diffs = 0;
      for (int i = 0; i < 128; i++)
         if (poly_mem[i] !== nom_mem[i] || wcount[i] != 1) diffs++;
      chk({tag, "_ram_diffs"}, 64'(diffs), 64'd0);
   endtask

   initial begin
      bit hit;
      int d0;
      for (int i = 0; i < 32; i++) msg_mem[i] = 8'(i);
      reset = 1'b1; set = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      reset = 1'b0;

      // Nominal job
      push_job(128, 1'b1, 1'b0);
      start_job();
      wait_done(2000);
      nominal_lat = done_cyc - start_cyc;
      check_queues("nominal");
      chk("addr4_word", 64'(poly_mem[4]), 64'h0000_0681);
      chk("addr8_word", 64'(poly_mem[8]), 64'h0681_0000);
      chk("addr124_word", 64'(poly_mem[124]), 64'h0681_0681);
      chk("addr127_word", 64'(poly_mem[127]), 64'h0000_0000);
      for (int i = 0; i < 128; i++) nom_mem[i] = exp_word(i);
      check_ram("nominal");

      // Random backpressure
      bp_mode = 1'b1;
      push_job(128, 1'b1, 1'b0);
      start_job();
      wait_done(6000);
      bp_mode = 1'b0;
      check_queues("backpressure");
      check_ram("backpressure");

      // Ordering fault at pair 4
      fault_pair = 4;
      push_job(4, 1'b1, 1'b1);
      start_job();
      wait_done(2000);
      in_q.delete();
      check_queues("fault");
      chk("fault_no_addr4", 64'(wcount[4]), 64'd0);
      chk("fault_done_within_2", 64'((done_cyc - bad_cyc >= 1) && (done_cyc - bad_cyc <= 2)), 64'd1);
      fault_pair = -1;

      // Timeout after pair 10
      stop_at = 11;
      push_job(11, 1'b1, 1'b1);
      start_job();
      wait_done(4000);
      check_queues("timeout");
      chk("timeout_gap", 64'(done_cyc - last_xfer_cyc), 64'(TIMEOUT));
      stop_at = -1;

      // Start while busy, then set low for 7 cycles
      push_job(128, 1'b1, 1'b0);
      start_job();
      repeat (18) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(posedge clk);
      #1 set = 1'b0;
      repeat (7) @(posedge clk);
      #1 set = 1'b1;
      wait_done(2000);
      chk("gated_latency", 64'(done_cyc - start_cyc), 64'(nominal_lat + 7));
      repeat (20) @(posedge clk);
      #1;
      chk("no_second_job", 64'(busy), 64'd0);
      check_queues("gated");
      check_ram("gated");

      // Reset at pair 50, then a clean job
      push_job(50, 1'b0, 1'b0);
      start_job();
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (mp == 50) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reached_pair50", 64'(hit), 64'd1);
      reset = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      check_idle("reset_mid");
      reset = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
      in_q.delete();
      check_queues("reset_mid");

      push_job(128, 1'b1, 1'b0);
      start_job();
      wait_done(2000);
      check_queues("after_reset");
      check_ram("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
